// File: rtl/bc_msg_merger_pkg.sv
// Shared message layout for the broadcast merger: field offsets and default width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Message format {addr, strb[3:0], data[31:0]}; addr fills the bits above ADDR_LSB.
package bc_msg_defs;

  localparam int DATA_LSB          = 0;
  localparam int DATA_W            = 32;
  localparam int STRB_LSB          = 32;
  localparam int STRB_W            = 4;
  localparam int ADDR_LSB          = 36;
  localparam int MSG_WIDTH_DEFAULT = 46;
  localparam int CNT_W             = 32;

  // Index width for an N-entry selector; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bc_msg_merger_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
// Latency: grant is combinational from req_i; pointer advances on the ack edge.
// Backpressure: none inside; the caller asserts ack_i only when the grant is taken.
//
// Ports:
//   clk_i, rst_i  clock and async active-high reset
//   req_i[N]      per-requester request
//   ack_i         grant consumed this cycle; advance pointer past the winner
//   grant_o[N]    one-hot grant, zero when nothing requests
//   grant_idx_o   index of the granted requester (pointer value when idle)
module rr_arbiter
  import bc_msg_defs::*;
#(
  parameter int N  = 16,
  parameter int IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          ack_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  logic [IW-1:0] sel;
  logic [IW:0]   cand_w;
  logic [IW-1:0] cand;

  // Scan N candidates starting at the pointer. The sum is kept one bit wider
  // and reduced by N explicitly so non-power-of-2 N wraps correctly.
  always_comb begin
    found  = 1'b0;
    sel    = ptr_q;
    cand_w = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand_w = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand_w >= (IW+1)'(N)) begin
        cand_w = cand_w - (IW+1)'(N);
      end
      cand = cand_w[IW-1:0];
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (found) begin
      grant_o = {{(N-1){1'b0}}, 1'b1} << sel;
    end
  end

  assign grant_idx_o = sel;

  // Pointer lands just past the winner, so a continuously requesting core
  // waits at most N-1 grants.
  always_comb begin
    ptr_d = ptr_q;
    if (ack_i && found) begin
      ptr_d = (sel == IW'(N-1)) ? '0 : sel + IW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bc_msg_merger.sv
// Merges per-core broadcast messages into one bus fanned back to every core.
// Latency: PIPE_STAGES cycles from the transfer edge to bc_msg_valid; 1 msg/cycle.
// Backpressure: none on the output; inputs see ready only for the round-robin winner.
//
// Ports:
//   sys_clk, sys_rst   clock and async active-high reset
//   core_msg           per-core message, core i at [i*MSG_WIDTH +: MSG_WIDTH]
//   core_msg_valid     per-core valid (held with data until ready)
//   core_msg_ready     per-core ready, one-hot or zero, zero while sys_rst is high
//   bc_msg             broadcast message (last pipeline stage)
//   bc_msg_valid       one-cycle pulse per broadcast message
//   msg_count          transfers taken        (only with BC_MSG_STATS_EN)
//   stall_count        cycles with >=2 valids (only with BC_MSG_STATS_EN)
// Optional feature macro: BC_MSG_STATS_EN adds the two 32-bit wrapping counters.
module bc_msg_merger
  import bc_msg_defs::*;
#(
  parameter int CORE_COUNT  = 16,
  parameter int MSG_WIDTH   = MSG_WIDTH_DEFAULT,
  parameter int PIPE_STAGES = 1,
  parameter int PTR_WIDTH   = $clog2(CORE_COUNT)
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
  input  logic [CORE_COUNT-1:0]           core_msg_valid,
  output logic [CORE_COUNT-1:0]           core_msg_ready,
  output logic [MSG_WIDTH-1:0]            bc_msg,
  output logic                            bc_msg_valid
`ifdef BC_MSG_STATS_EN
  ,
  output logic [CNT_W-1:0]                msg_count,
  output logic [CNT_W-1:0]                stall_count
`endif
);

  logic [CORE_COUNT-1:0] grant;
  logic [PTR_WIDTH-1:0]  grant_idx;
  logic                  xfer;
  logic [MSG_WIDTH-1:0]  sel_msg;
  logic [MSG_WIDTH-1:0]  msg_arr [CORE_COUNT];

  logic [MSG_WIDTH-1:0]   pipe_dat_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pipe_vld_q;

  // Ready is masked during reset so no core can believe it handed off a
  // message in a cycle whose state is about to be cleared.
  assign core_msg_ready = sys_rst ? '0 : grant;
  assign xfer           = |(core_msg_valid & core_msg_ready);

  rr_arbiter #(
    .N  (CORE_COUNT),
    .IW (PTR_WIDTH)
  ) u_arb (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .req_i       (core_msg_valid),
    .ack_i       (xfer),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_unpack
    assign msg_arr[i] = core_msg[i*MSG_WIDTH +: MSG_WIDTH];
  end

  assign sel_msg = msg_arr[grant_idx];

  // Output pipeline shifts every cycle; stage 0 data only loads on a
  // transfer, otherwise its (invalid) contents are left alone.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        pipe_dat_q[s] <= '0;
      end
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= xfer;
      if (xfer) begin
        pipe_dat_q[0] <= sel_msg;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pipe_dat_q[s] <= pipe_dat_q[s-1];
        pipe_vld_q[s] <= pipe_vld_q[s-1];
      end
    end
  end

  assign bc_msg       = pipe_dat_q[PIPE_STAGES-1];
  assign bc_msg_valid = pipe_vld_q[PIPE_STAGES-1];

`ifdef BC_MSG_STATS_EN
  logic [CNT_W-1:0] msg_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             multi_req;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_req = |(core_msg_valid & (core_msg_valid - CORE_COUNT'(1)));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      msg_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      msg_cnt_q   <= msg_cnt_q + CNT_W'(xfer);
      stall_cnt_q <= stall_cnt_q + CNT_W'(multi_req);
    end
  end

  assign msg_count   = msg_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bc_msg_merger.sv
module tb_bc_msg_merger;
  import bc_msg_defs::*;

  localparam int MW = 46;
  localparam int NA = 16;
  localparam int PA = 1;
  localparam int NB = 5;
  localparam int PB = 3;

  typedef struct {
    logic [MW-1:0] msg;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // DUT A: 16 cores, 1 stage
  logic               rst_a;
  logic [NA*MW-1:0]   msg_a;
  logic [NA-1:0]      vld_a;
  logic [NA-1:0]      rdy_a;
  logic [MW-1:0]      bc_a;
  logic               bcv_a;
  // DUT B: 5 cores, 3 stages
  logic               rst_b;
  logic [NB*MW-1:0]   msg_b;
  logic [NB-1:0]      vld_b;
  logic [NB-1:0]      rdy_b;
  logic [MW-1:0]      bc_b;
  logic               bcv_b;
`ifdef BC_MSG_STATS_EN
  logic [31:0] mcnt_a, scnt_a, mcnt_b, scnt_b;
`endif

  bc_msg_merger #(.CORE_COUNT(NA), .MSG_WIDTH(MW), .PIPE_STAGES(PA)) dut_a (
    .sys_clk        (clk),
    .sys_rst        (rst_a),
    .core_msg       (msg_a),
    .core_msg_valid (vld_a),
    .core_msg_ready (rdy_a),
    .bc_msg         (bc_a),
    .bc_msg_valid   (bcv_a)
`ifdef BC_MSG_STATS_EN
    ,
    .msg_count      (mcnt_a),
    .stall_count    (scnt_a)
`endif
  );

  bc_msg_merger #(.CORE_COUNT(NB), .MSG_WIDTH(MW), .PIPE_STAGES(PB)) dut_b (
    .sys_clk        (clk),
    .sys_rst        (rst_b),
    .core_msg       (msg_b),
    .core_msg_valid (vld_b),
    .core_msg_ready (rdy_b),
    .bc_msg         (bc_b),
    .bc_msg_valid   (bcv_b)
`ifdef BC_MSG_STATS_EN
    ,
    .msg_count      (mcnt_b),
    .stall_count    (scnt_b)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Core i always presents addr=i+16, strb=i[3:0], data=i.
  function automatic logic [MW-1:0] mk_msg(input int i);
    logic [MW-1:0] m;
    m = '0;
    m[DATA_LSB +: DATA_W] = 32'(i);
    m[STRB_LSB +: STRB_W] = 4'(i);
    m[ADDR_LSB +: 10]     = 10'(i + 16);
    return m;
  endfunction

  // One cycle of stimulus: drive valids, check the expected winner's ready,
  // queue its message for arrival PIPE cycles after the transfer edge.
  task automatic step_a(input logic [NA-1:0] v, input int g);
    @(posedge clk); #1;
    vld_a = v;
    @(negedge clk);
    chk("a_ready", 64'(rdy_a), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) q_a.push_back('{msg: mk_msg(g), cyc: cyc + PA});
  endtask

  task automatic step_b(input logic [NB-1:0] v, input int g);
    @(posedge clk); #1;
    vld_b = v;
    @(negedge clk);
    chk("b_ready", 64'(rdy_b), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) q_b.push_back('{msg: mk_msg(g), cyc: cyc + PB});
  endtask

  // Monitors: every output pulse must match the oldest expectation at the
  // expected cycle; an expectation whose cycle passes unseen is a failure.
  always @(negedge clk) begin
    exp_t e;
    if (bcv_a) begin
      if (q_a.size() == 0) chk("a_unexpected_valid", 64'(bcv_a), 64'd0);
      else begin
        e = q_a.pop_front();
        chk("a_msg", 64'(bc_a), 64'(e.msg));
        chk("a_latency", 64'(cyc), 64'(e.cyc));
      end
    end else if (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
      e = q_a.pop_front();
      chk("a_missing_valid", 64'(bcv_a), 64'd1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bcv_b) begin
      if (q_b.size() == 0) chk("b_unexpected_valid", 64'(bcv_b), 64'd0);
      else begin
        e = q_b.pop_front();
        chk("b_msg", 64'(bc_b), 64'(e.msg));
        chk("b_latency", 64'(cyc), 64'(e.cyc));
      end
    end else if (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
      e = q_b.pop_front();
      chk("b_missing_valid", 64'(bcv_b), 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    vld_a = '1;
    vld_b = '1;
    for (int i = 0; i < NA; i++) msg_a[i*MW +: MW] = mk_msg(i);
    for (int i = 0; i < NB; i++) msg_b[i*MW +: MW] = mk_msg(i);

    // Reset held with every core valid: no ready, no output.
    repeat (3) @(negedge clk);
    chk("a_reset_ready", 64'(rdy_a), 64'd0);
    chk("a_reset_valid", 64'(bcv_a), 64'd0);
    chk("a_reset_msg",   64'(bc_a),  64'd0);
    chk("b_reset_ready", 64'(rdy_b), 64'd0);
    chk("b_reset_valid", 64'(bcv_b), 64'd0);

    // Release with all valid: first grant is core 0, then 1..15,0,1.
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_first_grant", 64'(rdy_a), 64'd1);
    q_a.push_back('{msg: mk_msg(0), cyc: cyc + PA});
    for (int k = 1; k < 18; k++) step_a('1, k % 16);

    // Only core 5: back-to-back grants, pointer then sits at 6 so 7 beats 3.
    for (int k = 0; k < 4; k++) step_a(16'h0020, 5);
    step_a(16'h0088, 7);
    step_a(16'h0008, 3);
    repeat (3) step_a('0, -1);

`ifdef BC_MSG_STATS_EN
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("a_msg_count_reset",   64'(mcnt_a), 64'd0);
    chk("a_stall_count_reset", 64'(scnt_a), 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int k = 0; k < 10; k++) step_a(16'h0006, (k % 2 == 0) ? 1 : 2);
    step_a('0, -1);
    chk("a_msg_count",   64'(mcnt_a), 64'd10);
    chk("a_stall_count", 64'(scnt_a), 64'd10);
`endif

    // Five cores, three stages: wrap at a non-power-of-2 count.
    @(posedge clk); #1;
    vld_b = '0;
    rst_b = 1'b0;
    step_b(5'b01000, 3);   // pointer -> 4
    step_b(5'b10001, 4);   // pointer wraps -> 0
    step_b(5'b00001, 0);   // pointer -> 1
    step_b(5'b10010, 1);
    step_b(5'b10000, 4);   // pointer wraps -> 0 again
    step_b(5'b01001, 0);
    for (int k = 0; k < 5; k++) step_b('1, (k + 1) % 5);

    // Three in flight, then reset: all discarded, nothing leaks out.
    step_b('1, 1);
    step_b('1, 2);
    step_b('1, 3);
    @(posedge clk); #1;
    rst_b = 1'b1;
    q_b.delete();
    @(negedge clk);
    chk("b_midreset_ready", 64'(rdy_b), 64'd0);
    chk("b_midreset_valid", 64'(bcv_b), 64'd0);
    chk("b_midreset_msg",   64'(bc_b),  64'd0);
    @(negedge clk);
    chk("b_midreset_ready2", 64'(rdy_b), 64'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    vld_b = '0;
    for (int k = 0; k < 3; k++) begin
      step_b('0, -1);
      chk("b_post_reset_valid", 64'(bcv_b), 64'd0);
    end
    step_b('1, 0);
    step_b(5'b11110, 1);
    repeat (5) step_b('0, -1);

    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
